// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: state encoding and width constants.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam int WRAP_W    = 3;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes, sticky expiry
// flag with acknowledge, reload counter and overrun detection.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              LOAD,
    input  logic [WIDTH-1:0]  LOAD_VAL,
    input  logic              PERIODIC,
    input  logic              PAUSE,
    input  logic              CLEAR,
    input  logic              EXPIRE_ACK,
    output logic [WIDTH-1:0]  CNT,
    output logic              BUSY,
    output logic              EXPIRE,
    output logic [WRAP_W-1:0] WRAP_CNT,
    output logic              OVERRUN
);

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic               periodic_q, periodic_d;
    logic               expire_q, expire_d;
    logic [WRAP_W-1:0]  wrap_q, wrap_d;
    logic               overrun_q, overrun_d;
    logic               busy_q;
    logic               ack_eff;

    assign ack_eff = EXPIRE_ACK && expire_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        expire_d   = expire_q;
        wrap_d     = wrap_q;
        overrun_d  = overrun_q;

        if (CLEAR) begin
            state_d   = IDLE;
            cnt_d     = '0;
            expire_d  = 1'b0;
            wrap_d    = '0;
            overrun_d = 1'b0;
        end else if (LOAD) begin
            reload_d   = LOAD_VAL;
            periodic_d = PERIODIC;
            wrap_d     = '0;
            overrun_d  = 1'b0;
            if (LOAD_VAL != '0) begin
                cnt_d    = LOAD_VAL;
                expire_d = 1'b0;
                state_d  = RUN;
            end else begin
                // A zero load has nothing to count: expire immediately.
                cnt_d    = '0;
                expire_d = 1'b1;
                state_d  = EXPIRED;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ack_eff) expire_d = 1'b0;
                end
                RUN: begin
                    if (!PAUSE) begin
                        if (ack_eff) expire_d = 1'b0;
                        if (cnt_q > CNT_ONE) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else if (cnt_q == CNT_ONE) begin
                            // A new expiry overrides a coincident acknowledge.
                            expire_d = 1'b1;
                            if (periodic_q) begin
                                cnt_d  = reload_q;
                                wrap_d = wrap_q + WRAP_ONE;
                                if (expire_q && !EXPIRE_ACK) overrun_d = 1'b1;
                            end else begin
                                cnt_d   = '0;
                                state_d = EXPIRED;
                            end
                        end
                    end
                end
                EXPIRED: begin
                    if (ack_eff) begin
                        expire_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
            wrap_q     <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            expire_q   <= expire_d;
            wrap_q     <= wrap_d;
            overrun_q  <= overrun_d;
            busy_q     <= (state_d == RUN);
        end
    end

    assign CNT      = cnt_q;
    assign BUSY     = busy_q;
    assign EXPIRE   = expire_q;
    assign WRAP_CNT = wrap_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the width of the count and load value.
REQ-002 Port CLK SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port RSTN SHALL be an input, 1 bit wide, and SHALL be the reset: asynchronous, active-low.
REQ-004 Port LOAD SHALL be an input, 1 bit wide, meaning start or restart the timer with LOAD_VAL.
REQ-005 Port LOAD_VAL SHALL be an input, WIDTH bits wide, meaning the start value and the reload value; it is sampled only when LOAD=1.
REQ-006 Port PERIODIC SHALL be an input, 1 bit wide, meaning 1 selects auto-reload mode and 0 selects one-shot mode; it is sampled only when LOAD=1.
REQ-007 Port PAUSE SHALL be an input, 1 bit wide, meaning hold the count in RUN.
REQ-008 Port CLEAR SHALL be an input, 1 bit wide, meaning synchronous abort to IDLE.
REQ-009 Port EXPIRE_ACK SHALL be an input, 1 bit wide, meaning acknowledge of EXPIRE.
REQ-010 Port CNT SHALL be an output, WIDTH bits wide, meaning the current count.
REQ-011 Port BUSY SHALL be an output, 1 bit wide, meaning the state is RUN.
REQ-012 Port EXPIRE SHALL be an output, 1 bit wide, meaning a sticky expiry flag, held until acknowledged.
REQ-013 Port WRAP_CNT SHALL be an output, 3 bits wide, meaning the number of periodic reloads since the last LOAD, modulo 8.
REQ-014 Port OVERRUN SHALL be an output, 1 bit wide, meaning an expiry occurred while EXPIRE was already 1; sticky.

Function
REQ-015 The state machine SHALL have the states IDLE, RUN and EXPIRED, and SHALL leave reset in IDLE.
REQ-016 Per-cycle priority SHALL be CLEAR > LOAD > PAUSE > decrement.
REQ-017 CLEAR SHALL drive the next state to IDLE and set CNT=0, EXPIRE=0, WRAP_CNT=0 and OVERRUN=0, from any state.
REQ-018 LOAD in any state SHALL capture LOAD_VAL and PERIODIC into internal reload registers and clear EXPIRE, WRAP_CNT and OVERRUN.
REQ-019 LOAD with LOAD_VAL!=0 SHALL set CNT=LOAD_VAL and the next state to RUN.
REQ-020 LOAD with LOAD_VAL=0 SHALL set CNT=0, EXPIRE=1 and the next state to EXPIRED, regardless of PERIODIC.
REQ-021 In RUN with PAUSE=1, CNT and all flags SHALL hold.
REQ-022 In RUN with PAUSE=0 and CNT>1, CNT SHALL decrement by 1 per cycle, with no wrap below 0.
REQ-023 In RUN with PAUSE=0, CNT=1 and one-shot mode: CNT SHALL become 0, EXPIRE SHALL become 1, and the next state SHALL be EXPIRED.
REQ-024 In RUN with PAUSE=0, CNT=1 and periodic mode: CNT SHALL become the reload value, EXPIRE SHALL become 1, WRAP_CNT SHALL increment (7 wraps to 0), and the state SHALL stay RUN.
REQ-025 Latency: a LOAD with value N sampled at edge k SHALL give CNT=N after edge k and EXPIRE=1 after edge k+N, absent PAUSE.
REQ-026 EXPIRE_ACK with EXPIRE=1 SHALL clear EXPIRE on the next edge, and in EXPIRED SHALL move the state to IDLE.
REQ-027 EXPIRE_ACK with EXPIRE=0 SHALL have no effect.
REQ-028 If EXPIRE_ACK coincides with a new periodic expiry, the expiry SHALL win: EXPIRE stays 1 and OVERRUN is not set.
REQ-029 A periodic expiry with EXPIRE=1 and no EXPIRE_ACK in the same cycle SHALL set OVERRUN=1.
REQ-030 IDLE SHALL hold CNT, ignore PAUSE, and ignore EXPIRE_ACK unless EXPIRE=1.
REQ-031 BUSY SHALL be 1 exactly when the state is RUN.
REQ-032 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.

Reset
REQ-033 RSTN=0 SHALL asynchronously force the state to IDLE and CNT=0, EXPIRE=0, WRAP_CNT=0, OVERRUN=0, BUSY=0, and set the reload registers to 0 (one-shot).
REQ-034 Assertion of RSTN mid-RUN SHALL abort the run with no EXPIRE; the state SHALL stay in IDLE after release until a LOAD.

Structure
REQ-035 A shared package SHALL hold the state enumeration (IDLE, RUN, EXPIRED), the WRAP_CNT width constant (3) and the default WIDTH constant (8).
REQ-036 The design SHALL be a single module with no sub-module; the reload registers, state register and counters live together.

Verification
REQ-037 The bench SHALL cover one-shot: LOAD_VAL=3, PERIODIC=0 at cycle 0 -> CNT 3,2,1,0 on cycles 1-4; EXPIRE=1 from cycle 4; BUSY=0 from cycle 4; ACK at cycle 6 -> EXPIRE=0 and IDLE at cycle 7.
REQ-038 The bench SHALL cover periodic: LOAD_VAL=2, PERIODIC=1, ACK each expiry -> CNT 2,1,2,1,...; WRAP_CNT increments every 2 cycles and reads 0 after 8 wraps; OVERRUN stays 0.
REQ-039 The bench SHALL cover overrun: LOAD_VAL=1, PERIODIC=1, no ACK -> EXPIRE=1 after the first expiry; OVERRUN=1 after the second expiry; CLEAR -> all outputs 0 and IDLE.
REQ-040 The bench SHALL cover pause and priority: LOAD_VAL=5, PAUSE for 3 cycles at CNT=4 -> CNT holds 4 and EXPIRE arrives 3 cycles late; CLEAR and LOAD in the same cycle -> IDLE with CNT=0.
REQ-041 The bench SHALL cover the zero load and ACK collision: LOAD_VAL=0 -> EXPIRED and EXPIRE=1 after one edge; periodic expiry coinciding with ACK -> EXPIRE stays 1 and OVERRUN=0.
REQ-042 The bench SHALL cover reset mid-run: RSTN low at CNT=3 -> all outputs 0 immediately, without waiting for a clock edge; after release, no activity until LOAD.
